// File: rtl/usb_eop_seq.sv
// USB TX line-state sequencer: drives EOP (SE0 bits then J bits) or a long-SE0 bus reset
// onto D+/D- at a programmable bit period, with busy/done handshake and synchronous abort.
module usb_eop_seq #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SE0_BITS     = 2,
    parameter int J_BITS       = 1,
    parameter int RST_BITS     = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start,
    input  logic mode,
    input  logic low_speed,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic drive_en,
    output logic d_plus,
    output logic d_minus
);

    localparam int MAX_SJ   = (SE0_BITS > J_BITS) ? SE0_BITS : J_BITS;
    localparam int MAX_BITS = (MAX_SJ > RST_BITS) ? MAX_SJ : RST_BITS;
    localparam int CLK_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W    = $clog2(MAX_BITS + 1);

    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] CLK_ONE  = CLK_W'(1);
    localparam logic [BIT_W-1:0] SE0_LAST = BIT_W'(SE0_BITS - 1);
    localparam logic [BIT_W-1:0] J_LAST   = BIT_W'(J_BITS - 1);
    localparam logic [BIT_W-1:0] RST_LAST = BIT_W'(RST_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SE0,
        ST_J,
        ST_FIN
    } state_t;

    state_t            state, state_nx;
    logic [CLK_W-1:0]  clk_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_last;
    logic              mode_q, ls_q;
    logic              clk_wrap, phase_end, accept, cnt_clr;

    assign clk_wrap  = (clk_cnt == CLK_LAST);
    assign phase_end = clk_wrap && (bit_cnt == bit_last);
    assign accept    = (state == ST_IDLE) && start && !abort;

    always_comb begin
        bit_last = J_LAST;
        if (state == ST_SE0)
            bit_last = mode_q ? RST_LAST : SE0_LAST;
    end

    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        case (state)
            ST_IDLE: if (accept) begin
                state_nx = ST_SE0;
                cnt_clr  = 1'b1;
            end
            ST_SE0: if (phase_end) begin
                state_nx = mode_q ? ST_FIN : ST_J;
                cnt_clr  = 1'b1;
            end
            ST_J: if (phase_end) begin
                state_nx = ST_FIN;
                cnt_clr  = 1'b1;
            end
            ST_FIN: begin
                state_nx = ST_IDLE;
                cnt_clr  = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_clr  = 1'b1;
            end
        endcase
        // Abort overrides everything, including a start seen in the same cycle.
        if (abort) begin
            state_nx = ST_IDLE;
            cnt_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            mode_q  <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mode_q <= mode;
                ls_q   <= low_speed;
            end
            if (cnt_clr) begin
                clk_cnt <= '0;
                bit_cnt <= '0;
            end else if (state == ST_SE0 || state == ST_J) begin
                if (clk_wrap) begin
                    clk_cnt <= '0;
                    bit_cnt <= bit_cnt + BIT_ONE;
                end else begin
                    clk_cnt <= clk_cnt + CLK_ONE;
                end
            end
        end
    end

    // Moore outputs; the idle lines rest at J of the most recently latched speed.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        drive_en = 1'b0;
        d_plus   = ~ls_q;
        d_minus  = ls_q;
        case (state)
            ST_SE0: begin
                busy     = 1'b1;
                drive_en = 1'b1;
                d_plus   = 1'b0;
                d_minus  = 1'b0;
            end
            ST_J: begin
                busy     = 1'b1;
                drive_en = 1'b1;
            end
            ST_FIN:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
